// File: rtl/net_rx_failover_ctrl_if.sv
// net_rx_failover_ctrl_if
//   One EthernetRxBus stream: a 64-bit data beat with its qualifiers.
//   master drives the stream and slave consumes it.
//
//   data        64  beat payload
//   data_valid   1  data carries a payload beat
//   start        1  first beat of a frame
//   commit       1  last beat of a good frame
//   drop         1  frame aborted; discard everything since start
interface net_rx_failover_ctrl_if;
  logic [63:0] data;
  logic        data_valid;
  logic        start;
  logic        commit;
  logic        drop;

  modport master (output data, data_valid, start, commit, drop);
  modport slave  (input  data, data_valid, start, commit, drop);
endinterface

// File: rtl/net_rx_failover_ctrl.sv
// net_rx_failover_ctrl
//   Chooses which RX port (SFP or RGMII) feeds the core-side RX stream.
//   A port must show link up for HOLDOFF_CYCLES consecutive cycles before
//   it can be selected. The controller only switches between frames, and
//   it aborts a frame cleanly with a single drop beat when the selected
//   link is lost.
//
//   clk            in   core clock
//   rst            in   asynchronous active-high reset
//   sfp_link_up    in   SFP link state, already synchronous to clk
//   rgmii_link_up  in   RGMII link state, already synchronous to clk
//   sfp_rx_bus     in   SFP RX stream (slave)
//   rgmii_rx_bus   in   RGMII RX stream (slave)
//   eth_link_up    out  a port is currently selected
//   eth_rx_bus     out  selected stream, one-cycle registered (master)
//   active_port    out  0 = none, 1 = SFP, 2 = RGMII
//   switch_count   out  number of selection changes, saturating
//
//   state  | meaning
//   NONE   | no port selected, output idle
//   SYNC   | port selected, waiting for its next frame start
//   ACTIVE | forwarding the selected port
//   DRAIN  | a switch is pending; finishing the current frame first
module net_rx_failover_ctrl #(
  parameter int HOLDOFF_CYCLES = 250000,
  parameter bit PREFER_SFP     = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sfp_link_up,
  input  logic                          rgmii_link_up,
  net_rx_failover_ctrl_if.slave         sfp_rx_bus,
  net_rx_failover_ctrl_if.slave         rgmii_rx_bus,
  output logic                          eth_link_up,
  net_rx_failover_ctrl_if.master        eth_rx_bus,
  output logic [1:0]                    active_port,
  output logic [15:0]                   switch_count
);

  localparam int QW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [QW-1:0] HOLD_Q = QW'(HOLDOFF_CYCLES);

  localparam logic [1:0] PORT_NONE  = 2'd0;
  localparam logic [1:0] PORT_SFP   = 2'd1;
  localparam logic [1:0] PORT_RGMII = 2'd2;

  typedef enum logic [1:0] {ST_NONE, ST_SYNC, ST_ACTIVE, ST_DRAIN} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic        data_valid;
    logic        start;
    logic        commit;
    logic        drop;
  } beat_t;

  state_t      state_q, state_d;
  logic [1:0]  port_q, port_d;
  logic        in_frame_q, in_frame_d;
  beat_t       out_q, out_d;
  logic [15:0] count_q;
  logic [QW-1:0] sfp_cnt, rgmii_cnt;
  logic        sfp_qual, rgmii_qual, sel_qual, do_switch;
  logic [1:0]  desired;
  beat_t       sfp_beat, rgmii_beat, sel_beat;

  // Link qualification: the counter restarts on any low cycle and the port
  // is disqualified combinationally the moment its link reads low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sfp_cnt   <= '0;
      rgmii_cnt <= '0;
    end else begin
      if (!sfp_link_up)          sfp_cnt <= '0;
      else if (sfp_cnt != HOLD_Q) sfp_cnt <= sfp_cnt + QW'(1);
      if (!rgmii_link_up)          rgmii_cnt <= '0;
      else if (rgmii_cnt != HOLD_Q) rgmii_cnt <= rgmii_cnt + QW'(1);
    end
  end

  assign sfp_qual   = sfp_link_up   && (sfp_cnt   == HOLD_Q);
  assign rgmii_qual = rgmii_link_up && (rgmii_cnt == HOLD_Q);

  always_comb begin
    desired = PORT_NONE;
    if (PREFER_SFP) begin
      if (sfp_qual)        desired = PORT_SFP;
      else if (rgmii_qual) desired = PORT_RGMII;
    end else begin
      if (rgmii_qual)      desired = PORT_RGMII;
      else if (sfp_qual)   desired = PORT_SFP;
    end
  end

  always_comb begin
    sfp_beat.data         = sfp_rx_bus.data;
    sfp_beat.data_valid   = sfp_rx_bus.data_valid;
    sfp_beat.start        = sfp_rx_bus.start;
    sfp_beat.commit       = sfp_rx_bus.commit;
    sfp_beat.drop         = sfp_rx_bus.drop;
    rgmii_beat.data       = rgmii_rx_bus.data;
    rgmii_beat.data_valid = rgmii_rx_bus.data_valid;
    rgmii_beat.start      = rgmii_rx_bus.start;
    rgmii_beat.commit     = rgmii_rx_bus.commit;
    rgmii_beat.drop       = rgmii_rx_bus.drop;
  end

  assign sel_beat = (port_q == PORT_RGMII) ? rgmii_beat : sfp_beat;

  always_comb begin
    sel_qual = 1'b0;
    if (port_q == PORT_SFP)        sel_qual = sfp_qual;
    else if (port_q == PORT_RGMII) sel_qual = rgmii_qual;
  end

  // Frame state after a forwarded beat; a start that also ends the frame
  // leaves us outside a frame.
  function automatic logic frame_after(input logic cur, input beat_t b);
    if (b.commit || b.drop) return 1'b0;
    if (b.start)            return 1'b1;
    return cur;
  endfunction

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    in_frame_d = in_frame_q;
    out_d      = '0;
    do_switch  = 1'b0;

    case (state_q)
      ST_NONE: begin
        if (desired != PORT_NONE) do_switch = 1'b1;
      end
      ST_SYNC: begin
        // Nothing has been forwarded yet, so a reselection here is safe.
        if (desired != port_q) begin
          do_switch = 1'b1;
        end else if (sel_beat.start) begin
          out_d      = sel_beat;
          in_frame_d = frame_after(1'b0, sel_beat);
          state_d    = ST_ACTIVE;
        end
      end
      ST_ACTIVE, ST_DRAIN: begin
        if (desired == port_q) begin
          out_d      = sel_beat;
          in_frame_d = frame_after(in_frame_q, sel_beat);
          state_d    = ST_ACTIVE;
        end else if (!sel_qual) begin
          // Link lost: the current beat is untrustworthy, abort instead.
          if (in_frame_q) out_d.drop = 1'b1;
          do_switch = 1'b1;
        end else if (!in_frame_q) begin
          // Between frames; a beat arriving now is not forwarded, so the
          // core never sees a start without its end.
          do_switch = 1'b1;
        end else begin
          out_d      = sel_beat;
          in_frame_d = frame_after(in_frame_q, sel_beat);
          state_d    = ST_DRAIN;
        end
      end
      default: state_d = ST_NONE;
    endcase

    if (do_switch) begin
      port_d     = desired;
      in_frame_d = 1'b0;
      state_d    = (desired == PORT_NONE) ? ST_NONE : ST_SYNC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_NONE;
      port_q     <= PORT_NONE;
      in_frame_q <= 1'b0;
      out_q      <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      in_frame_q <= in_frame_d;
      out_q      <= out_d;
      if (port_d != port_q && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
    end
  end

  assign eth_link_up           = (state_q != ST_NONE);
  assign active_port           = port_q;
  assign switch_count          = count_q;
  assign eth_rx_bus.data       = out_q.data;
  assign eth_rx_bus.data_valid = out_q.data_valid;
  assign eth_rx_bus.start      = out_q.start;
  assign eth_rx_bus.commit     = out_q.commit;
  assign eth_rx_bus.drop       = out_q.drop;

endmodule

// File: tb/tb_net_rx_failover_ctrl.sv
module tb_net_rx_failover_ctrl;

  typedef struct packed {
    logic [63:0] data;
    logic        dv;
    logic        st;
    logic        cm;
    logic        dr;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        sfp_link_up;
  logic        rgmii_link_up;
  logic        eth_link_up;
  logic [1:0]  active_port;
  logic [15:0] switch_count;

  net_rx_failover_ctrl_if sfp_if ();
  net_rx_failover_ctrl_if rg_if ();
  net_rx_failover_ctrl_if eth_if ();

  net_rx_failover_ctrl #(.HOLDOFF_CYCLES(10), .PREFER_SFP(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .sfp_link_up   (sfp_link_up),
    .rgmii_link_up (rgmii_link_up),
    .sfp_rx_bus    (sfp_if),
    .rgmii_rx_bus  (rg_if),
    .eth_link_up   (eth_link_up),
    .eth_rx_bus    (eth_if),
    .active_port   (active_port),
    .switch_count  (switch_count)
  );

  int    total = 0;
  int    bad   = 0;
  beat_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic beat_t mk(input logic [63:0] d, input logic v, input logic s,
                               input logic c, input logic r);
    beat_t b;
    b.data = d; b.dv = v; b.st = s; b.cm = c; b.dr = r;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_sfp(input beat_t b);
    sfp_if.data = b.data; sfp_if.data_valid = b.dv; sfp_if.start = b.st;
    sfp_if.commit = b.cm; sfp_if.drop = b.dr;
  endtask

  task automatic drv_rg(input beat_t b);
    rg_if.data = b.data; rg_if.data_valid = b.dv; rg_if.start = b.st;
    rg_if.commit = b.cm; rg_if.drop = b.dr;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: every non-idle output beat must match the head of
  // the expected queue.
  always @(negedge clk) begin
    beat_t got, exp;
    if (!rst) begin
      got = {eth_if.data, eth_if.data_valid, eth_if.start, eth_if.commit, eth_if.drop};
      if (got != '0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got=%h expected=none at %0t", got, $time);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            bad++;
            $display("FAIL beat: got=%h expected=%h at %0t", got, exp, $time);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; sfp_link_up = 1'b0; rgmii_link_up = 1'b0;
    drv_sfp('0); drv_rg('0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_port", active_port, 0);
    chk("reset_link", eth_link_up, 0);
    chk("reset_count", switch_count, 0);

    // Short link pulses never qualify.
    rgmii_link_up = 1'b1; repeat (9) tick();
    rgmii_link_up = 1'b0; sfp_link_up = 1'b1; repeat (5) tick();
    sfp_link_up = 1'b0; repeat (3) tick();
    chk("pulse_port", active_port, 0);
    chk("pulse_link", eth_link_up, 0);

    // RGMII qualifies after the holdoff.
    rgmii_link_up = 1'b1;
    repeat (10) tick();
    chk("holdoff_not_yet", active_port, 0);
    tick();
    chk("rg_select_port", active_port, 2);
    chk("rg_select_link", eth_link_up, 1);
    chk("rg_select_count", switch_count, 1);

    // In SYNC a stray mid-frame beat is suppressed; the frame from start is forwarded.
    drv_rg(mk(64'h11, 1, 0, 0, 0)); tick();
    drv_rg(mk(64'h100, 1, 1, 0, 0)); exp_q.push_back(mk(64'h100, 1, 1, 0, 0)); tick();
    drv_rg(mk(64'h101, 1, 0, 0, 0)); exp_q.push_back(mk(64'h101, 1, 0, 0, 0)); tick();
    drv_rg(mk(64'h102, 1, 0, 1, 0)); exp_q.push_back(mk(64'h102, 1, 0, 1, 0)); tick();
    drv_rg('0); repeat (2) tick();

    // SFP qualifies while RGMII idle: preferred port takes over.
    sfp_link_up = 1'b1;
    repeat (10) tick();
    chk("pref_not_yet", active_port, 2);
    tick();
    chk("pref_switch_port", active_port, 1);
    chk("pref_switch_count", switch_count, 2);

    // SFP lost while idle: fall back to RGMII with no drop beat.
    sfp_link_up = 1'b0; tick();
    chk("idle_loss_port", active_port, 2);
    chk("idle_loss_count", switch_count, 3);

    // RGMII frame in flight when SFP qualifies: frame completes first.
    sfp_link_up = 1'b1;
    drv_rg(mk(64'h200, 1, 1, 0, 0)); exp_q.push_back(mk(64'h200, 1, 1, 0, 0)); tick();
    for (int i = 0; i < 40; i++) begin
      drv_rg(mk(64'h201 + 64'(i), 1, 0, 0, 0));
      exp_q.push_back(mk(64'h201 + 64'(i), 1, 0, 0, 0));
      if (i == 5) drv_sfp(mk(64'h900, 1, 1, 0, 0));
      else        drv_sfp(mk(64'h901 + 64'(i), 1, 0, 0, 0));
      tick();
    end
    drv_rg(mk(64'h300, 1, 0, 1, 0)); exp_q.push_back(mk(64'h300, 1, 0, 1, 0));
    drv_sfp(mk(64'h940, 1, 0, 0, 0)); tick();
    chk("drain_hold_port", active_port, 2);
    drv_rg('0); drv_sfp(mk(64'h950, 1, 0, 0, 0)); tick();
    chk("drain_switch_port", active_port, 1);
    chk("drain_switch_count", switch_count, 4);
    // Tail of the SFP frame already in progress is suppressed.
    drv_sfp(mk(64'h951, 1, 0, 0, 0)); tick();
    drv_sfp(mk(64'h952, 1, 0, 1, 0)); tick();
    drv_sfp(mk(64'hA00, 1, 1, 0, 0)); exp_q.push_back(mk(64'hA00, 1, 1, 0, 0)); tick();
    drv_sfp(mk(64'hA01, 1, 0, 0, 0)); exp_q.push_back(mk(64'hA01, 1, 0, 0, 0)); tick();
    drv_sfp(mk(64'hA02, 1, 0, 0, 0)); exp_q.push_back(mk(64'hA02, 1, 0, 0, 0)); tick();

    // SFP link lost mid-frame: one drop beat, then RGMII from its next start.
    sfp_link_up = 1'b0;
    drv_sfp(mk(64'hA03, 1, 0, 0, 0));
    drv_rg(mk(64'h400, 1, 0, 0, 0));
    exp_q.push_back(mk(64'h0, 0, 0, 0, 1));
    tick();
    chk("loss_port", active_port, 2);
    chk("loss_count", switch_count, 5);
    drv_sfp('0);
    drv_rg(mk(64'h401, 1, 0, 0, 0)); tick();
    drv_rg(mk(64'h402, 1, 1, 1, 0)); exp_q.push_back(mk(64'h402, 1, 1, 1, 0)); tick();
    drv_rg('0); repeat (2) tick();

    // Both links lost while idle.
    rgmii_link_up = 1'b0; tick();
    chk("both_loss_port", active_port, 0);
    chk("both_loss_link", eth_link_up, 0);
    chk("both_loss_count", switch_count, 6);
    repeat (2) tick();

    // Reset during a frame clears outputs at once and restarts qualification.
    rgmii_link_up = 1'b1;
    repeat (11) tick();
    chk("requal_port", active_port, 2);
    chk("requal_count", switch_count, 7);
    drv_rg(mk(64'h500, 1, 1, 0, 0)); exp_q.push_back(mk(64'h500, 1, 1, 0, 0)); tick();
    drv_rg(mk(64'h501, 1, 0, 0, 0)); exp_q.push_back(mk(64'h501, 1, 0, 0, 0)); tick();
    drv_rg(mk(64'h502, 1, 0, 0, 0)); tick();
    rst = 1'b1;
    #1;
    chk("rst_async_port", active_port, 0);
    chk("rst_async_link", eth_link_up, 0);
    chk("rst_async_count", switch_count, 0);
    chk("rst_async_valid", eth_if.data_valid, 0);
    chk("rst_async_data", eth_if.data[31:0], 0);
    drv_rg('0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("post_rst_not_yet", active_port, 0);
    tick();
    chk("post_rst_port", active_port, 2);
    chk("post_rst_count", switch_count, 1);
    repeat (3) tick();

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
